// File: rtl/id_ex_stage_pkg.sv
//==============================================================================
// Module      : id_ex_stage_pkg
// Description : Shared control-word layout, instruction field bounds and the
//               bubble constant for the ID/EX pipeline register.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package id_ex_stage_pkg;

    localparam int CTRL_W      = 8;
    localparam int INSTR_W     = 32;
    localparam int REG_FIELD_W = 5;
    localparam int IMM_W       = 16;

    // Bit positions inside the packed control word
    localparam int CTRL_REG_WRITE  = 7;
    localparam int CTRL_MEM_READ   = 6;
    localparam int CTRL_MEM_WRITE  = 5;
    localparam int CTRL_MEM_TO_REG = 4;
    localparam int CTRL_ALU_SRC    = 3;
    localparam int CTRL_REG_DST    = 2;
    localparam int CTRL_ALU_OP_HI  = 1;
    localparam int CTRL_ALU_OP_LO  = 0;

    // Instruction field bounds
    localparam int RS_HI  = 25;
    localparam int RS_LO  = 21;
    localparam int RT_HI  = 20;
    localparam int RT_LO  = 16;
    localparam int RD_HI  = 15;
    localparam int RD_LO  = 11;
    localparam int IMM_HI = 15;
    localparam int IMM_LO = 0;

    typedef struct packed {
        logic       regWrite;
        logic       memRead;
        logic       memWrite;
        logic       memToReg;
        logic       aluSrc;
        logic       regDst;
        logic [1:0] aluOp;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '0;

    function automatic logic [REG_FIELD_W-1:0] instrRs(input logic [INSTR_W-1:0] instr);
        return instr[RS_HI:RS_LO];
    endfunction

    function automatic logic [REG_FIELD_W-1:0] instrRt(input logic [INSTR_W-1:0] instr);
        return instr[RT_HI:RT_LO];
    endfunction

    function automatic logic [REG_FIELD_W-1:0] instrRd(input logic [INSTR_W-1:0] instr);
        return instr[RD_HI:RD_LO];
    endfunction

endpackage

`default_nettype wire

// File: rtl/id_ex_stage_if.sv
//==============================================================================
// Module      : id_ex_stage_if
// Description : Decode-side inputs and EX-side registered outputs of the
//               ID/EX stage; master drives decode, slave is the stage itself.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface id_ex_stage_if
    import id_ex_stage_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5
);

    logic                  valid_in;
    logic [INSTR_W-1:0]    instr_in;
    logic [DATA_W-1:0]     pc_plus4_in;
    logic [DATA_W-1:0]     readData1;
    logic [DATA_W-1:0]     readData2;
    logic [CTRL_W-1:0]     ctrl_in;
    logic                  flush_in;
    logic                  wb_regWrite;
    logic [REG_ADDR_W-1:0] wb_writeReg;
    logic [DATA_W-1:0]     wb_writeData;

    logic                  stall_out;
    logic                  ex_valid;
    logic [CTRL_W-1:0]     ex_ctrl;
    logic [DATA_W-1:0]     ex_data1;
    logic [DATA_W-1:0]     ex_data2;
    logic [DATA_W-1:0]     ex_imm;
    logic [DATA_W-1:0]     ex_pc_plus4;
    logic [REG_ADDR_W-1:0] ex_rs;
    logic [REG_ADDR_W-1:0] ex_rt;
    logic [REG_ADDR_W-1:0] ex_rd;

    modport master (
        output valid_in, instr_in, pc_plus4_in, readData1, readData2, ctrl_in,
               flush_in, wb_regWrite, wb_writeReg, wb_writeData,
        input  stall_out, ex_valid, ex_ctrl, ex_data1, ex_data2, ex_imm,
               ex_pc_plus4, ex_rs, ex_rt, ex_rd
    );

    modport slave (
        input  valid_in, instr_in, pc_plus4_in, readData1, readData2, ctrl_in,
               flush_in, wb_regWrite, wb_writeReg, wb_writeData,
        output stall_out, ex_valid, ex_ctrl, ex_data1, ex_data2, ex_imm,
               ex_pc_plus4, ex_rs, ex_rt, ex_rd
    );

endinterface

`default_nettype wire

// File: rtl/id_ex_stage_hazard_detect.sv
//==============================================================================
// Module      : hazard_detect
// Description : Load-use hazard detector; flags a decode instruction that
//               reads the destination of a load currently in EX.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module hazard_detect #(
    parameter int REG_ADDR_W = 5
) (
    input  wire logic                  i_validIn,
    input  wire logic                  i_exValid,
    input  wire logic                  i_exMemRead,
    input  wire logic [REG_ADDR_W-1:0] i_exRt,
    input  wire logic [REG_ADDR_W-1:0] i_rs,
    input  wire logic [REG_ADDR_W-1:0] i_rt,
    output logic                       o_stall
);

    logic w_rtNonZero;
    logic w_srcMatch;

    // A load into r0 never produces a value anyone can depend on
    assign w_rtNonZero = (i_exRt != '0);
    assign w_srcMatch  = (i_exRt == i_rs) || (i_exRt == i_rt);
    assign o_stall     = i_validIn & i_exValid & i_exMemRead & w_rtNonZero & w_srcMatch;

endmodule

`default_nettype wire

// File: rtl/id_ex_stage.sv
//==============================================================================
// Module      : id_ex_stage
// Description : ID/EX pipeline register with load-use stall, flush and r0
//               operand zeroing. Optional macro ID_EX_WB_BYPASS_EN forwards
//               the write-back port into the captured operands.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5
) (
    input  wire logic     clock_in,
    input  wire logic     reset_n,
    id_ex_stage_if.slave  bus
);

    logic [REG_ADDR_W-1:0] w_rs;
    logic [REG_ADDR_W-1:0] w_rt;
    logic [REG_ADDR_W-1:0] w_rd;
    logic [DATA_W-1:0]     w_imm;
    logic [DATA_W-1:0]     w_src1;
    logic [DATA_W-1:0]     w_src2;
    logic [DATA_W-1:0]     w_op1;
    logic [DATA_W-1:0]     w_op2;
    logic                  w_stall;
    logic                  w_bubble;
    logic                  w_unusedBits;

    assign w_rs  = REG_ADDR_W'(instrRs(bus.instr_in));
    assign w_rt  = REG_ADDR_W'(instrRt(bus.instr_in));
    assign w_rd  = REG_ADDR_W'(instrRd(bus.instr_in));
    assign w_imm = {{(DATA_W-IMM_W){bus.instr_in[IMM_HI]}}, bus.instr_in[IMM_HI:IMM_LO]};

`ifdef ID_EX_WB_BYPASS_EN
    logic w_wbHit1;
    logic w_wbHit2;

    assign w_wbHit1 = bus.wb_regWrite && (bus.wb_writeReg != '0) && (bus.wb_writeReg == w_rs);
    assign w_wbHit2 = bus.wb_regWrite && (bus.wb_writeReg != '0) && (bus.wb_writeReg == w_rt);
    assign w_src1   = w_wbHit1 ? bus.wb_writeData : bus.readData1;
    assign w_src2   = w_wbHit2 ? bus.wb_writeData : bus.readData2;
    assign w_unusedBits = ^bus.instr_in[INSTR_W-1:RS_HI+1];
`else
    assign w_src1 = bus.readData1;
    assign w_src2 = bus.readData2;
    assign w_unusedBits = ^{bus.instr_in[INSTR_W-1:RS_HI+1], bus.wb_regWrite,
                            bus.wb_writeReg, bus.wb_writeData};
`endif

    // r0 reads as zero even if a stale or forwarded value is present
    assign w_op1 = (w_rs == '0) ? '0 : w_src1;
    assign w_op2 = (w_rt == '0) ? '0 : w_src2;

    hazard_detect #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_hazard_detect (
        .i_validIn   (bus.valid_in),
        .i_exValid   (bus.ex_valid),
        .i_exMemRead (bus.ex_ctrl[CTRL_MEM_READ]),
        .i_exRt      (bus.ex_rt),
        .i_rs        (w_rs),
        .i_rt        (w_rt),
        .o_stall     (w_stall)
    );

    assign bus.stall_out = w_stall;
    assign w_bubble      = bus.flush_in | w_stall | ~bus.valid_in;

    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            bus.ex_valid    <= 1'b0;
            bus.ex_ctrl     <= CTRL_BUBBLE;
            bus.ex_data1    <= '0;
            bus.ex_data2    <= '0;
            bus.ex_imm      <= '0;
            bus.ex_pc_plus4 <= '0;
            bus.ex_rs       <= '0;
            bus.ex_rt       <= '0;
            bus.ex_rd       <= '0;
        end else if (w_bubble) begin
            bus.ex_valid    <= 1'b0;
            bus.ex_ctrl     <= CTRL_BUBBLE;
            bus.ex_data1    <= '0;
            bus.ex_data2    <= '0;
            bus.ex_imm      <= '0;
            bus.ex_pc_plus4 <= '0;
            bus.ex_rs       <= '0;
            bus.ex_rt       <= '0;
            bus.ex_rd       <= '0;
        end else begin
            bus.ex_valid    <= 1'b1;
            bus.ex_ctrl     <= bus.ctrl_in;
            bus.ex_data1    <= w_op1;
            bus.ex_data2    <= w_op2;
            bus.ex_imm      <= w_imm;
            bus.ex_pc_plus4 <= bus.pc_plus4_in;
            bus.ex_rs       <= w_rs;
            bus.ex_rt       <= w_rt;
            bus.ex_rd       <= w_rd;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_id_ex_stage.sv
//==============================================================================
// Module      : tb_id_ex_stage
// Description : Self-checking bench for id_ex_stage: directed cases plus
//               randomized traffic against a behavioural model.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_id_ex_stage;

    localparam int DATA_W     = 32;
    localparam int REG_ADDR_W = 5;

    localparam logic [7:0] CTRL_LW   = 8'hD8;
    localparam logic [7:0] CTRL_ADDI = 8'h88;
    localparam logic [7:0] CTRL_ADD  = 8'h86;

    logic clock_in = 1'b0;
    logic reset_n  = 1'b1;

    always #5 clock_in = ~clock_in;

    id_ex_stage_if #(.DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W)) bus ();

    id_ex_stage #(.DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W)) dut (
        .clock_in (clock_in),
        .reset_n  (reset_n),
        .bus      (bus)
    );

    int vectors     = 0;
    int miscompares = 0;
    bit checkEn     = 1'b0;

    // Behavioural model of what EX should hold
    logic        mValid;
    logic [7:0]  mCtrl;
    logic [31:0] mD1, mD2, mImm, mPc;
    logic [4:0]  mRs, mRt, mRd;

    logic [4:0]  rRs, rRt;
    bit          held;

    function automatic logic [31:0] mkI(input logic [4:0] rs, input logic [4:0] rt, input logic [15:0] imm);
        return {6'h08, rs, rt, imm};
    endfunction

    function automatic logic [31:0] mkR(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
        return {6'h00, rs, rt, rd, 11'h020};
    endfunction

    function automatic logic modelStall();
        logic [4:0] rs, rt;
        rs = bus.instr_in[25:21];
        rt = bus.instr_in[20:16];
        return bus.valid_in && mValid && mCtrl[6] && (mRt != 0) && (mRt == rs || mRt == rt);
    endfunction

    function automatic logic [31:0] expOperand(input logic [4:0] idx, input logic [31:0] rf);
        if (idx == 0) return 32'h0;
`ifdef ID_EX_WB_BYPASS_EN
        if (bus.wb_regWrite && bus.wb_writeReg == idx) return bus.wb_writeData;
`endif
        return rf;
    endfunction

    always @(posedge clock_in or negedge reset_n) begin
        if (!reset_n || bus.flush_in || modelStall() || !bus.valid_in) begin
            mValid <= 1'b0; mCtrl <= 8'h0;
            mD1 <= 0; mD2 <= 0; mImm <= 0; mPc <= 0;
            mRs <= 0; mRt <= 0; mRd <= 0;
        end else begin
            mValid <= 1'b1;
            mCtrl  <= bus.ctrl_in;
            mD1    <= expOperand(bus.instr_in[25:21], bus.readData1);
            mD2    <= expOperand(bus.instr_in[20:16], bus.readData2);
            mImm   <= 32'(signed'(bus.instr_in[15:0]));
            mPc    <= bus.pc_plus4_in;
            mRs    <= bus.instr_in[25:21];
            mRt    <= bus.instr_in[20:16];
            mRd    <= bus.instr_in[15:11];
        end
    end

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clock_in) begin
        if (checkEn) begin
            cmp("m_stall",    32'(bus.stall_out),  32'(modelStall()));
            cmp("m_valid",    32'(bus.ex_valid),   32'(mValid));
            cmp("m_ctrl",     32'(bus.ex_ctrl),    32'(mCtrl));
            cmp("m_data1",    bus.ex_data1,        mD1);
            cmp("m_data2",    bus.ex_data2,        mD2);
            cmp("m_imm",      bus.ex_imm,          mImm);
            cmp("m_pc",       bus.ex_pc_plus4,     mPc);
            cmp("m_rs",       32'(bus.ex_rs),      32'(mRs));
            cmp("m_rt",       32'(bus.ex_rt),      32'(mRt));
            cmp("m_rd",       32'(bus.ex_rd),      32'(mRd));
        end
    end

    task automatic tick();
        @(posedge clock_in);
        #1;
    endtask

    task automatic checkAllZero(input string tag);
        cmp({tag, "_valid"}, 32'(bus.ex_valid),  32'h0);
        cmp({tag, "_ctrl"},  32'(bus.ex_ctrl),   32'h0);
        cmp({tag, "_d1"},    bus.ex_data1,       32'h0);
        cmp({tag, "_d2"},    bus.ex_data2,       32'h0);
        cmp({tag, "_imm"},   bus.ex_imm,         32'h0);
        cmp({tag, "_pc"},    bus.ex_pc_plus4,    32'h0);
        cmp({tag, "_idx"},   32'({bus.ex_rs, bus.ex_rt, bus.ex_rd}), 32'h0);
        cmp({tag, "_stall"}, 32'(bus.stall_out), 32'h0);
    endtask

    task automatic randomDecode();
        bus.valid_in     = ($urandom_range(0, 99) < 85);
        bus.flush_in     = ($urandom_range(0, 99) < 10);
        bus.ctrl_in      = 8'($urandom);
        bus.ctrl_in[6]   = ($urandom_range(0, 99) < 40);
        if (!held) begin
            rRs = 5'($urandom_range(0, 7));
            rRt = 5'($urandom_range(0, 7));
            bus.instr_in = {6'($urandom), rRs, rRt, 16'($urandom)};
        end
        bus.pc_plus4_in  = $urandom;
        bus.readData1    = $urandom;
        bus.readData2    = $urandom;
        bus.wb_regWrite  = 1'($urandom);
        bus.wb_writeReg  = 5'($urandom_range(0, 7));
        bus.wb_writeData = $urandom;
    endtask

    initial begin
        bus.valid_in = 0; bus.instr_in = 0; bus.pc_plus4_in = 0;
        bus.readData1 = 0; bus.readData2 = 0; bus.ctrl_in = 0; bus.flush_in = 0;
        bus.wb_regWrite = 0; bus.wb_writeReg = 0; bus.wb_writeData = 0;
        held = 1'b0;

        // Asynchronous reset between clock edges
        #2 reset_n = 1'b0;
        #1 checkAllZero("rst0");
        checkEn = 1'b1;
        @(negedge clock_in); #2 reset_n = 1'b1;
        tick();

        // ADDI rs=1 rt=2 imm=0xFFFC
        bus.valid_in = 1; bus.instr_in = mkI(5'd1, 5'd2, 16'hFFFC); bus.ctrl_in = CTRL_ADDI;
        bus.readData1 = 32'd7; bus.readData2 = 32'd9; bus.pc_plus4_in = 32'h100;
        tick();
        cmp("addi_d1",    bus.ex_data1,        32'd7);
        cmp("addi_imm",   bus.ex_imm,          32'hFFFF_FFFC);
        cmp("addi_ctrl",  32'(bus.ex_ctrl),    32'(CTRL_ADDI));
        cmp("addi_valid", 32'(bus.ex_valid),   32'h1);
        cmp("addi_pc",    bus.ex_pc_plus4,     32'h100);
        cmp("addi_rt",    32'(bus.ex_rt),      32'd2);

        // LW rt=3 followed by dependent ADD rs=3
        bus.instr_in = mkI(5'd4, 5'd3, 16'h0010); bus.ctrl_in = CTRL_LW; bus.readData1 = 32'h40;
        tick();
        bus.instr_in = mkR(5'd3, 5'd6, 5'd7); bus.ctrl_in = CTRL_ADD;
        bus.readData1 = 32'h11; bus.readData2 = 32'h22;
        #1 cmp("lu_stall", 32'(bus.stall_out), 32'h1);
        tick();
        cmp("lu_bub_valid", 32'(bus.ex_valid), 32'h0);
        cmp("lu_bub_ctrl",  32'(bus.ex_ctrl),  32'h0);
        cmp("lu_bub_d1",    bus.ex_data1,      32'h0);
        cmp("lu_stall_drop", 32'(bus.stall_out), 32'h0);
        tick();
        cmp("lu_add_ctrl", 32'(bus.ex_ctrl), 32'(CTRL_ADD));
        cmp("lu_add_d1",   bus.ex_data1,     32'h11);
        cmp("lu_add_rd",   32'(bus.ex_rd),   32'd7);

        // LW into r0 never stalls; r0 operand captured as zero
        bus.instr_in = mkI(5'd4, 5'd0, 16'h0008); bus.ctrl_in = CTRL_LW;
        tick();
        bus.instr_in = mkR(5'd0, 5'd5, 5'd9); bus.ctrl_in = CTRL_ADD;
        bus.readData1 = 32'h55; bus.readData2 = 32'h66;
        #1 cmp("r0_stall", 32'(bus.stall_out), 32'h0);
        tick();
        cmp("r0_d1",    bus.ex_data1,      32'h0);
        cmp("r0_d2",    bus.ex_data2,      32'h66);
        cmp("r0_valid", 32'(bus.ex_valid), 32'h1);

        // Flush coinciding with a load-use hazard
        bus.instr_in = mkI(5'd4, 5'd3, 16'h0004); bus.ctrl_in = CTRL_LW;
        tick();
        bus.instr_in = mkR(5'd3, 5'd2, 5'd8); bus.ctrl_in = CTRL_ADD;
        bus.readData1 = 32'h31; bus.flush_in = 1;
        #1 cmp("fl_stall", 32'(bus.stall_out), 32'h1);
        tick();
        cmp("fl_valid", 32'(bus.ex_valid), 32'h0);
        cmp("fl_ctrl",  32'(bus.ex_ctrl),  32'h0);
        bus.flush_in = 0;
        #1 cmp("fl_stall_clr", 32'(bus.stall_out), 32'h0);
        tick();
        cmp("fl_add_d1", bus.ex_data1, 32'h31);

        // Write-back forwarding into rs
        bus.instr_in = mkR(5'd5, 5'd6, 5'd1); bus.ctrl_in = CTRL_ADD;
        bus.readData1 = 32'h0; bus.readData2 = 32'h77;
        bus.wb_regWrite = 1; bus.wb_writeReg = 5'd5; bus.wb_writeData = 32'h1234;
        tick();
`ifdef ID_EX_WB_BYPASS_EN
        cmp("byp_d1", bus.ex_data1, 32'h1234);
`else
        cmp("byp_d1", bus.ex_data1, 32'h0);
`endif
        cmp("byp_d2", bus.ex_data2, 32'h77);
        bus.wb_regWrite = 0;

        // Randomized traffic; a stalled instruction is re-presented
        for (int i = 0; i < 3000; i++) begin
            randomDecode();
            #1 held = modelStall() && !bus.flush_in;
            tick();
        end

        // Reset dropped mid-stream between edges
        @(negedge clock_in); #2 reset_n = 1'b0;
        #1 checkAllZero("rst1");
        @(negedge clock_in); #2 reset_n = 1'b1;
        held = 1'b0;
        for (int i = 0; i < 500; i++) begin
            randomDecode();
            #1 held = modelStall() && !bus.flush_in;
            tick();
        end

        @(negedge clock_in);
        #1 checkEn = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 Parameter DATA_W, default 32, datapath width of register operands, immediate and PC.
REQ-002 Parameter REG_ADDR_W, default 5, register index width.
REQ-003 clock_in  input  1  single clock; all state updates on its rising edge.
REQ-004 reset_n  input  1  reset, asynchronous and active-low.
REQ-005 valid_in  input  1  decode slot holds a real instruction.
REQ-006 instr_in  input  32  decoded instruction word; rs=[25:21], rt=[20:16], rd=[15:11], imm=[15:0].
REQ-007 pc_plus4_in  input  DATA_W  PC+4 of decode instruction.
REQ-008 readData1, readData2  input  DATA_W each  register-file read ports for rs/rt.
REQ-009 ctrl_in  input  8  {regWrite, memRead, memWrite, memToReg, aluSrc, regDst, aluOp[1:0]}.
REQ-010 flush_in  input  1  kill decode instruction (taken branch/jump).
REQ-011 wb_regWrite, wb_writeReg, wb_writeData  input  1/REG_ADDR_W/DATA_W  write-back port, same values driven into the register file.
REQ-012 stall_out  output  1  load-use hazard; upstream holds PC and IF/ID.
REQ-013 ex_valid  output  1  EX slot valid.
REQ-014 ex_ctrl  output  8  registered control, same packing as ctrl_in.
REQ-015 ex_data1, ex_data2, ex_imm, ex_pc_plus4  output  DATA_W each  registered operands, sign-extended immediate, PC+4.
REQ-016 ex_rs, ex_rt, ex_rd  output  REG_ADDR_W each  registered register indices.

Function
REQ-017 Load condition: rising edge with stall_out=0 and flush_in=0 captures all decode inputs into EX outputs; ex_valid<=valid_in.
REQ-018 ex_imm = {{16{instr_in[15]}}, instr_in[15:0]}, sign-extended to DATA_W.
REQ-019 Operand for index 0 captured as 0 regardless of readData or bypass.
REQ-020 stall_out combinational = valid_in & ex_valid & ex_ctrl.memRead & ex_rt!=0 & (ex_rt==rs | ex_rt==rt).
REQ-021 stall_out=1 at edge: EX loads bubble (ex_valid=0, ex_ctrl=0, data/indices 0); decode instruction re-presented next cycle, stall then drops since ex_ctrl.memRead=0; max one stall cycle per load.
REQ-022 flush_in=1 at edge: EX loads bubble; flush priority over stall and load.
REQ-023 valid_in=0 with no stall/flush: bubble captured, ex_ctrl forced 0.
REQ-024 Only ex_ctrl and ex_valid gate downstream side effects; bubble never asserts regWrite/memWrite.

Reset
REQ-025 reset_n low: immediately ex_valid=0, ex_ctrl=0, ex_data1/2=0, ex_imm=0, ex_pc_plus4=0, ex_rs/rt/rd=0; stall_out therefore 0.
REQ-026 Reset deassertion mid-stream: first capture at first rising edge with reset_n high.

Configuration
REQ-027 Macro ID_EX_WB_BYPASS_EN defined: when wb_regWrite=1, wb_writeReg!=0 and wb_writeReg equals rs (rt), ex_data1 (ex_data2) captures wb_writeData instead of readData1 (readData2).
REQ-028 Macro undefined: readData1/readData2 captured unmodified; wb_* inputs unused.

Structure
REQ-029 Shared package holds ctrl bit-position constants, CTRL_W=8, instruction field bounds, bubble constant.
REQ-030 One sub-module hazard_detect (combinational stall_out); capture register in id_ex_stage.

Verification
REQ-031 Reset: assert reset_n=0 mid-cycle -> all outputs 0 without waiting for clock.
REQ-032 ADDI rs=1 rt=2 imm=0xFFFC, readData1=7 -> next edge ex_data1=7, ex_imm=0xFFFFFFFC, ex_ctrl=ctrl_in, ex_valid=1.
REQ-033 LW rt=3 in EX, decode ADD rs=3 -> stall_out=1; next edge bubble; following cycle stall_out=0, ADD captured.
REQ-034 LW rt=0 in EX, decode rs=0 -> stall_out=0; ex_data1=0 even with readData1=0x55.
REQ-035 flush_in=1 and stall condition together -> bubble, ex_ctrl=0, stall clears next cycle.
REQ-036 With ID_EX_WB_BYPASS_EN: wb_regWrite=1, wb_writeReg=5, wb_writeData=0x1234, rs=5, readData1=0 -> ex_data1=0x1234; without macro ex_data1=0.
